// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS_N/MOSI in the clk domain, shifts 8-bit
// MSB-first frames in both directions, and hands received bytes to local
// logic as a one-cycle pulse. Transmit bytes come from a one-entry buffer.
module spi_slave #(
    parameter bit CPOL = 1'b0,  // idle level of SCLK
    parameter bit CPHA = 1'b0   // 0: sample leading / shift trailing, 1: the reverse
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       SCLK,
    input  logic       CS_N,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state, state_d;

    logic       sclk_m, sclk_s, sclk_d;
    logic       cs_m, cs_s;
    logic       mosi_m, mosi_s;

    logic [2:0] bit_cnt, bit_cnt_d;
    logic [7:0] rx_shift, rx_shift_d;
    logic [7:0] tx_shift, tx_shift_d;
    logic [7:0] buf_data;
    logic       buf_full;

    logic       lead_edge, trail_edge;
    logic       sample_edge, shift_edge;
    logic       consume;
    logic       rx_done;

    // Two-flop synchronizers on the bus inputs, plus a history flop on SCLK.
    // Idle values (CPOL on SCLK, deselected on CS_N) keep reset from looking
    // like an edge or a select.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_m <= CPOL;
            sclk_s <= CPOL;
            sclk_d <= CPOL;
            cs_m   <= 1'b1;
            cs_s   <= 1'b1;
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the value
            // from before this edge; blocking here would collapse the chain.
            sclk_m <= SCLK;
            sclk_s <= sclk_m;
            sclk_d <= sclk_s;
            cs_m   <= CS_N;
            cs_s   <= cs_m;
            mosi_m <= MOSI;
            mosi_s <= mosi_m;
        end
    end

    // Leading edge leaves the idle level, trailing edge returns to it.
    assign lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    // Next-state and datapath decode for the frame FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        rx_shift_d = rx_shift;
        tx_shift_d = tx_shift;
        consume    = 1'b0;
        rx_done    = 1'b0;

        case (state)
            IDLE: begin
                if (!cs_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 3'd0;
                    // With CPHA=0 the first bit must be on MISO before the
                    // first leading edge, so the byte is fetched at select.
                    consume   = !CPHA;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    // Deselect aborts any partial byte; the buffer is kept.
                    state_d    = IDLE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 8'h00;
                    tx_shift_d = 8'h00;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = {rx_shift[6:0], mosi_s};
                        bit_cnt_d  = bit_cnt + 3'd1;
                        rx_done    = (bit_cnt == 3'd7);
                    end
                    if (shift_edge) begin
                        // bit_cnt==0 here means a byte boundary: fetch the next byte.
                        if (bit_cnt == 3'd0) begin
                            consume = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty buffer at fetch time sends zeros.
        if (consume) begin
            tx_shift_d = buf_full ? buf_data : 8'h00;
        end
    end

    // Frame state, shift registers and the received-byte output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            tx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            rx_shift <= rx_shift_d;
            tx_shift <= tx_shift_d;
            rx_valid <= rx_done;
            if (rx_done) begin
                rx_data <= rx_shift_d;
            end
        end
    end

    // Single-entry transmit holding buffer and underrun flag. A fetch of a
    // full buffer wins over a simultaneous tx_load, which is then ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_data    <= 8'h00;
            buf_full    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= consume && !buf_full;
            if (consume && buf_full) begin
                buf_full <= 1'b0;
            end else if (tx_load && !buf_full) begin
                buf_full <= 1'b1;
                buf_data <= tx_data;
            end
        end
    end

    assign tx_ready = !buf_full;
    assign busy     = (state == SHIFT);
    assign MISO     = (state == SHIFT) && tx_shift[7];

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: one instance per SPI mode, a bus-master
// model driving each, and a scoreboard of expected received bytes.
module tb_spi_slave;

    localparam int HALF = 8;  // SCLK half-period in clk cycles

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sclk        [4];
    logic       cs_n        [4];
    logic       mosi        [4];
    logic       miso        [4];
    logic [7:0] tx_data     [4];
    logic       tx_load     [4];
    logic       tx_ready    [4];
    logic [7:0] rx_data     [4];
    logic       rx_valid    [4];
    logic       tx_underrun [4];
    logic       busy        [4];

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q [$];
    int rv_total    = 0;
    int ur_total    = 0;
    int cyc         = 0;
    int rv_cyc_last = 0;
    int rv_cyc_prev = 0;

    always #5 clk = ~clk;

    // Mode m = {CPOL, CPHA}.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave #(
            .CPOL(1'((g >> 1) & 1)),
            .CPHA(1'(g & 1))
        ) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .SCLK       (sclk[g]),
            .CS_N       (cs_n[g]),
            .MOSI       (mosi[g]),
            .MISO       (miso[g]),
            .tx_data    (tx_data[g]),
            .tx_load    (tx_load[g]),
            .tx_ready   (tx_ready[g]),
            .rx_data    (rx_data[g]),
            .rx_valid   (rx_valid[g]),
            .tx_underrun(tx_underrun[g]),
            .busy       (busy[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid cycle pops one expected byte.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rx_valid[i] === 1'b1) begin
                logic [7:0] exp;
                exp = 8'hxx;
                if (rx_q.size() > 0) exp = rx_q.pop_front();
                check("rx_byte", {24'h0, rx_data[i]}, {24'h0, exp});
                rv_total++;
                rv_cyc_prev = rv_cyc_last;
                rv_cyc_last = cyc;
            end
            if (tx_underrun[i] === 1'b1) ur_total++;
        end
        cyc++;
    end

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic load(input int m, input logic [7:0] d);
        @(negedge clk);
        tx_data[m] = d;
        tx_load[m] = 1'b1;
        @(negedge clk);
        tx_load[m] = 1'b0;
        @(negedge clk);
    endtask

    task automatic cs_low(input int m);
        @(negedge clk);
        cs_n[m] = 1'b0;
        half_period();
    endtask

    task automatic cs_high(input int m);
        half_period();
        cs_n[m] = 1'b1;
        mosi[m] = 1'b0;
        half_period();
    endtask

    // Master side of nbits bit-times; returns the bits seen on MISO.
    task automatic xfer(input int m, input logic [7:0] mo, input int nbits,
                        output logic [7:0] mi);
        logic cpol, cpha;
        cpol = 1'((m >> 1) & 1);
        cpha = 1'(m & 1);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi[m] = mo[7-i];
                half_period();
                sclk[m] = ~cpol;
                mi = {mi[6:0], miso[m]};
                half_period();
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = mo[7-i];
                half_period();
                sclk[m] = cpol;
                mi = {mi[6:0], miso[m]};
                half_period();
            end
        end
    endtask

    initial begin
        logic [7:0] mi;
        int rv0, ur0;

        for (int i = 0; i < 4; i++) begin
            sclk[i]    = 1'((i >> 1) & 1);
            cs_n[i]    = 1'b1;
            mosi[i]    = 1'b0;
            tx_data[i] = 8'h00;
            tx_load[i] = 1'b0;
        end
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Reset values
        check("rst_miso",     {31'h0, miso[0]},        32'h0);
        check("rst_tx_ready", {31'h0, tx_ready[0]},    32'h1);
        check("rst_rx_data",  {24'h0, rx_data[0]},     32'h0);
        check("rst_rx_valid", {31'h0, rx_valid[0]},    32'h0);
        check("rst_underrun", {31'h0, tx_underrun[0]}, 32'h0);
        check("rst_busy",     {31'h0, busy[0]},        32'h0);

        // Mode 0: buffer 0xA5 out, 0x3C in
        load(0, 8'hA5);
        check("m0_ready_after_load", {31'h0, tx_ready[0]}, 32'h0);
        rv0 = rv_total;
        rx_q.push_back(8'h3C);
        cs_low(0);
        check("m0_ready_after_csn", {31'h0, tx_ready[0]}, 32'h1);
        check("m0_busy", {31'h0, busy[0]}, 32'h1);
        xfer(0, 8'h3C, 8, mi);
        cs_high(0);
        check("m0_miso_byte", {24'h0, mi}, 32'hA5);
        check("m0_rx_pulses", rv_total - rv0, 32'd1);
        check("m0_miso_idle", {31'h0, miso[0]}, 32'h0);
        check("m0_busy_idle", {31'h0, busy[0]}, 32'h0);

        // Modes 1..3: buffer 0x81 out, 0xC3 in
        for (int m = 1; m < 4; m++) begin
            load(m, 8'h81);
            rx_q.push_back(8'hC3);
            cs_low(m);
            xfer(m, 8'hC3, 8, mi);
            cs_high(m);
            check($sformatf("m%0d_miso_byte", m), {24'h0, mi}, 32'h81);
            check($sformatf("m%0d_rx_data", m), {24'h0, rx_data[m]}, 32'hC3);
        end

        // Two bytes under one CS_N, buffer refilled with 0x55 during byte 1
        load(0, 8'h12);
        rv0 = rv_total;
        rx_q.push_back(8'hF0);
        rx_q.push_back(8'h0F);
        cs_low(0);
        load(0, 8'h55);
        xfer(0, 8'hF0, 8, mi);
        check("b2b_first_byte", {24'h0, mi}, 32'h12);
        xfer(0, 8'h0F, 8, mi);
        cs_high(0);
        check("b2b_second_byte", {24'h0, mi}, 32'h55);
        check("b2b_rx_pulses", rv_total - rv0, 32'd2);
        check("b2b_gap_ok", {31'h0, 1'((rv_cyc_last - rv_cyc_prev) >= 8 * HALF)}, 32'h1);

        // Empty buffer at frame start (mode 1): zeros out, one underrun
        ur0 = ur_total;
        rx_q.push_back(8'h5A);
        cs_low(1);
        xfer(1, 8'h5A, 8, mi);
        cs_high(1);
        check("ur_miso_zero", {24'h0, mi}, 32'h0);
        check("ur_pulses", ur_total - ur0, 32'd1);
        check("ur_rx_data", {24'h0, rx_data[1]}, 32'h5A);

        // Partial frame of 5 bits, then a full frame with 0x96
        rv0 = rv_total;
        cs_low(0);
        xfer(0, 8'hFF, 5, mi);
        cs_high(0);
        check("partial_no_pulse", rv_total - rv0, 32'd0);
        check("partial_rx_held", {24'h0, rx_data[0]}, 32'h0F);
        check("partial_busy_idle", {31'h0, busy[0]}, 32'h0);
        rx_q.push_back(8'h96);
        cs_low(0);
        xfer(0, 8'h96, 8, mi);
        cs_high(0);
        check("after_partial_rx", {24'h0, rx_data[0]}, 32'h96);
        check("after_partial_pulses", rv_total - rv0, 32'd1);

        // Reset mid-frame in mode 2
        load(2, 8'hFF);
        cs_low(2);
        load(2, 8'h33);
        xfer(2, 8'hFF, 4, mi);
        half_period();
        check("pre_rst_busy", {31'h0, busy[2]}, 32'h1);
        check("pre_rst_miso", {31'h0, miso[2]}, 32'h1);
        check("pre_rst_ready", {31'h0, tx_ready[2]}, 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_miso",     {31'h0, miso[2]},        32'h0);
        check("mid_rst_busy",     {31'h0, busy[2]},        32'h0);
        check("mid_rst_ready",    {31'h0, tx_ready[2]},    32'h1);
        check("mid_rst_rx_data",  {24'h0, rx_data[2]},     32'h0);
        check("mid_rst_rx_valid", {31'h0, rx_valid[2]},    32'h0);
        check("mid_rst_underrun", {31'h0, tx_underrun[2]}, 32'h0);
        cs_n[2] = 1'b1;
        sclk[2] = 1'b1;
        mosi[2] = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        load(2, 8'h5A);
        rx_q.push_back(8'h99);
        cs_low(2);
        xfer(2, 8'h99, 8, mi);
        cs_high(2);
        check("post_rst_miso_byte", {24'h0, mi}, 32'h5A);
        check("post_rst_rx_data", {24'h0, rx_data[2]}, 32'h99);

        check("rx_queue_drained", rx_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
